// File: rtl/arf132b256e1r1w0cbbehcaa4acw_latch_array_pkg.sv
// Shared defaults, legal parameter ranges and entry type for the latch-based
// 1R1W register file.
package arf132b256e1r1w0cbbehcaa4acw_latch_array_pkg;

    localparam int DWIDTH_DEF = 132;
    localparam int DEPTH_DEF  = 256;
    localparam int RD_LAT_DEF = 1;
    localparam int BYPASS_DEF = 1;

    localparam int DEPTH_MIN  = 2;
    localparam int DEPTH_MAX  = 1024;
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    typedef logic [DWIDTH_DEF-1:0] entry_t;

    function automatic int addr_width(input int depth);
        int w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/arf132b256e1r1w0cbbehcaa4acw_latch_wr_stage.sv
// Write path: phase-A staging flop captures the write on the rising edge,
// phase-B enables open exactly one entry latch while clk is low.
module arf132b256e1r1w0cbbehcaa4acw_latch_wr_stage #(
    parameter int DWIDTH = 132,
    parameter int DEPTH  = 256,
    parameter int AWIDTH = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [AWIDTH-1:0] wr_addr_i,
    input  logic [DWIDTH-1:0] wr_data_i,
    output logic              wr_acc_o,
    output logic [DWIDTH-1:0] stg_data_o,
    output logic [DEPTH-1:0]  lat_en_o
);

    logic              stg_vld_q;
    logic [AWIDTH-1:0] stg_addr_q;
    logic [DWIDTH-1:0] stg_data_q;

    // Out-of-range writes never reach the staging register.
    assign wr_acc_o   = wr_en_i && (int'(wr_addr_i) < DEPTH);
    assign stg_data_o = stg_data_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stg_vld_q  <= 1'b0;
            stg_addr_q <= '0;
            stg_data_q <= '0;
        end else begin
            stg_vld_q <= wr_acc_o;
            if (wr_acc_o) begin
                stg_addr_q <= wr_addr_i;
                stg_data_q <= wr_data_i;
            end
        end
    end

    // Enable is low whenever clk is high, so staging updates never leak in.
    always_comb begin
        lat_en_o = '0;
        if (!clk_i && stg_vld_q) begin
            lat_en_o[stg_addr_q] = 1'b1;
        end
    end

endmodule

// File: rtl/arf132b256e1r1w0cbbehcaa4acw_latch_array.sv
// Latch-array 1R1W register file with per-entry valid bits, optional
// same-address write forwarding and a 1- or 2-cycle read pipeline.
module arf132b256e1r1w0cbbehcaa4acw_latch_array
    import arf132b256e1r1w0cbbehcaa4acw_latch_array_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int RD_LAT = RD_LAT_DEF,
    parameter int BYPASS = BYPASS_DEF,
    localparam int AWIDTH = addr_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AWIDTH-1:0] rd_addr,
    output logic [DWIDTH-1:0] rd_data,
    output logic              rd_vld,
    output logic              rd_init
);

    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
        $error("RD_LAT must be 1 or 2");
    end
    if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_depth
        $error("DEPTH must be within 2..1024");
    end

    logic              wr_acc;
    logic [DWIDTH-1:0] stg_data;
    logic [DEPTH-1:0]  lat_en;
    logic [DEPTH-1:0]  valid_q;
    logic [DWIDTH-1:0] mem_rd [DEPTH];

    arf132b256e1r1w0cbbehcaa4acw_latch_wr_stage #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH),
        .AWIDTH (AWIDTH)
    ) u_wr_stage (
        .clk_i      (clk),
        .rst_i      (rst),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .wr_acc_o   (wr_acc),
        .stg_data_o (stg_data),
        .lat_en_o   (lat_en)
    );

    // Storage is deliberately not reset; valid bits mask stale contents.
    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        logic [DWIDTH-1:0] ent_q;
        always_latch begin
            if (lat_en[i]) begin
                ent_q <= stg_data;
            end
        end
        assign mem_rd[i] = ent_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_acc) begin
            valid_q[wr_addr] <= 1'b1;
        end
    end

    logic              rd_in;
    logic [AWIDTH-1:0] rd_idx;
    logic              rd_hit;
    logic              rd_init_d;
    logic [DWIDTH-1:0] rd_data_d;

    assign rd_in  = int'(rd_addr) < DEPTH;
    assign rd_idx = rd_in ? rd_addr : '0;
    assign rd_hit = (BYPASS != 0) && wr_acc && rd_en && (wr_addr == rd_addr);

    always_comb begin
        rd_init_d = rd_in && valid_q[rd_idx];
        rd_data_d = rd_init_d ? mem_rd[rd_idx] : '0;
        if (rd_hit) begin
            rd_init_d = 1'b1;
            rd_data_d = wr_data;
        end
    end

    logic              s1_vld_q;
    logic              s1_init_q;
    logic [DWIDTH-1:0] s1_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q  <= 1'b0;
            s1_init_q <= 1'b0;
            s1_data_q <= '0;
        end else begin
            s1_vld_q  <= rd_en;
            s1_init_q <= rd_en && rd_init_d;
            if (rd_en) begin
                s1_data_q <= rd_data_d;
            end
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic              s2_vld_q;
        logic              s2_init_q;
        logic [DWIDTH-1:0] s2_data_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                s2_vld_q  <= 1'b0;
                s2_init_q <= 1'b0;
                s2_data_q <= '0;
            end else begin
                s2_vld_q  <= s1_vld_q;
                s2_init_q <= s1_init_q;
                if (s1_vld_q) begin
                    s2_data_q <= s1_data_q;
                end
            end
        end

        assign rd_vld  = s2_vld_q;
        assign rd_init = s2_init_q;
        assign rd_data = s2_data_q;
    end else begin : g_lat1
        assign rd_vld  = s1_vld_q;
        assign rd_init = s1_init_q;
        assign rd_data = s1_data_q;
    end

endmodule
